sram_bank_arbiter: RTL

- Per-access scheduler between the 4-lane SIMT group and the 4-bank data SRAM.
- Latches one warp-wide memory request (up to 4 lanes) and routes each lane to its bank, selected by word-address bits [1:0].
- Serializes bank conflicts in lane-index order (lane 0 first).
- Returns per-lane read data and holds the core group stalled via busy until every lane is served.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/bank_pick.sv | 24 ++
 rtl/sram_bank_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SIMT-group to banked-SRAM access arbiter.
package sram_arb_pkg;

  localparam int unsigned NLANE  = 4;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = $clog2(NLANE);
  localparam int unsigned ROW_W  = ADDR_W - LANE_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef logic [LANE_W-1:0] lane_idx_t;

  // Banks are interleaved on the low word-address bits.
  function automatic lane_idx_t bank_of(input logic [ADDR_W-1:0] addr);
    return addr[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/bank_pick.sv
// Lowest-index pending-lane encoder for one bank: picks which lane this bank serves next.
module bank_pick
  import sram_arb_pkg::*;
#(
  parameter lane_idx_t BANK = '0
) (
  input  logic [NLANE-1:0] pending,
  input  lane_idx_t        lane_bank [NLANE],
  output logic             hit,
  output lane_idx_t        lane
);

  always_comb begin
    hit  = 1'b0;
    lane = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      if (!hit && pending[l] && (lane_bank[l] == BANK)) begin
        hit  = 1'b1;
        lane = lane_idx_t'(l);
      end
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Serializes one warp-wide request onto the banked data SRAM, lane 0 first on conflicts,
// and collects per-lane read data while holding the cores stalled via busy.
module sram_bank_arbiter
  import sram_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [NLANE-1:0]         lane_valid,
  input  logic [NLANE-1:0]         lane_we,
  input  logic [NLANE*ADDR_W-1:0]  lane_addr,
  input  logic [NLANE*DATA_W-1:0]  lane_wd,
  output logic [NLANE*DATA_W-1:0]  lane_rd,
  output logic                     done,
  output logic                     busy,
  output logic [NLANE-1:0]         bank_en,
  output logic [NLANE-1:0]         bank_we,
  output logic [NLANE*ROW_W-1:0]   bank_addr,
  output logic [NLANE*DATA_W-1:0]  bank_wd,
  input  logic [NLANE*DATA_W-1:0]  bank_rd
);

  state_t                  state, state_d;
  logic [NLANE-1:0]        pending;
  logic [NLANE-1:0]        we_q;
  logic [ADDR_W-1:0]       addr_q    [NLANE];
  logic [DATA_W-1:0]       wd_q      [NLANE];
  logic [NLANE-1:0]        rd_pend;
  lane_idx_t               rd_lane   [NLANE];
  logic [DATA_W-1:0]       lane_rd_q [NLANE];

  lane_idx_t               lane_bank [NLANE];
  logic [NLANE-1:0]        hit;
  lane_idx_t               pick      [NLANE];
  logic [NLANE-1:0]        issue_mask;

  always_comb begin
    for (int unsigned l = 0; l < NLANE; l++) begin
      lane_bank[l] = bank_of(addr_q[l]);
    end
  end

  for (genvar b = 0; b < NLANE; b++) begin : g_pick
    bank_pick #(.BANK(lane_idx_t'(b))) u_pick (
      .pending   (pending),
      .lane_bank (lane_bank),
      .hit       (hit[b]),
      .lane      (pick[b])
    );
  end

  always_comb begin
    issue_mask = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wd    = '0;
    if (state == ISSUE) begin
      for (int unsigned b = 0; b < NLANE; b++) begin
        if (hit[b]) begin
          bank_en[b]                      = 1'b1;
          bank_we[b]                      = we_q[pick[b]];
          bank_addr[b*ROW_W +: ROW_W]     = addr_q[pick[b]][ADDR_W-1:LANE_W];
          bank_wd[b*DATA_W +: DATA_W]     = wd_q[pick[b]];
          issue_mask[pick[b]]             = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req) state_d = (lane_valid != '0) ? ISSUE : DONE;
      ISSUE:   if ((pending & ~issue_mask) == '0) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  always_comb begin
    for (int unsigned l = 0; l < NLANE; l++) begin
      lane_rd[l*DATA_W +: DATA_W] = lane_rd_q[l];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      we_q      <= '0;
      addr_q    <= '{default: '0};
      wd_q      <= '{default: '0};
      rd_pend   <= '0;
      rd_lane   <= '{default: '0};
      lane_rd_q <= '{default: '0};
    end else begin
      state <= state_d;
      if (state == IDLE && req) begin
        pending <= lane_valid;
        we_q    <= lane_we;
        for (int unsigned l = 0; l < NLANE; l++) begin
          addr_q[l] <= lane_addr[l*ADDR_W +: ADDR_W];
          wd_q[l]   <= lane_wd[l*DATA_W +: DATA_W];
        end
      end else if (state == ISSUE) begin
        pending <= pending & ~issue_mask;
      end
      // Bank read data lags bank_en by one cycle; remember who asked so it lands in the right lane.
      for (int unsigned b = 0; b < NLANE; b++) begin
        rd_pend[b] <= (state == ISSUE) && hit[b] && !we_q[pick[b]];
        rd_lane[b] <= pick[b];
        if (rd_pend[b]) begin
          lane_rd_q[rd_lane[b]] <= bank_rd[b*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
